serial_adder: RTL



---
 rtl/serial_adder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial ripple adder with registered carry (optional Overflow via SERIAL_ADDER_OVF_EN)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             Carry,
  output logic             Overflow
`else
  output logic             Carry
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Full adder on the current LSBs, built as two half adders plus an OR.
  logic ha1_s, ha1_c, ha2_s, ha2_c, c_nxt;
  assign ha1_s = a_q[0] ^ b_q[0];
  assign ha1_c = a_q[0] & b_q[0];
  assign ha2_s = ha1_s ^ c_q;
  assign ha2_c = ha1_s & c_q;
  assign c_nxt = ha1_c | ha2_c;

  // Next-state and datapath: capture in IDLE, one bit per edge in SHIFT, publish on the last bit.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start) begin
          a_d     = A;
          b_d     = B;
          c_d     = Cin;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_d = {ha2_s, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = c_nxt;
        if (cnt_q == LAST_BIT) begin
          sum_d   = {ha2_s, res_q[WIDTH-1:1]};
          carry_d = c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
          // c_q here is the carry into the MSB, c_nxt the carry out of it.
          ovf_d   = c_q ^ c_nxt;
`endif
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Sum   = sum_q;
  assign Carry = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign Overflow = ovf_q;
`endif

endmodule
